decimal_entry: RTL and testbench

- Sequential keypad-style decimal entry for the board. It is the input-side counterpart of the binary-to-decimal result display used by the arithmetic exercises.
- The user sets one BCD digit on switches and pulses an enter switch or button. The block accumulates acc = acc*10 + digit into a binary value and echoes the last digit on the seven-segment display.
- A commit pulse hands the binary number to downstream arithmetic logic (adder/subtractor operands), with overflow and invalid-digit detection.

---
 rtl/decimal_entry_pkg.sv | 44 ++++
 rtl/edge_sync.sv | 29 ++
 rtl/decimal_entry.sv | 136 +++++++++++++
 tb/tb_decimal_entry.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/decimal_entry_pkg.sv
// Shared types, seven-segment patterns and the BCD decoder for decimal_entry.
package decimal_entry_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ENTRY = 2'd1,
      FULL  = 2'd2,
      ERROR = 2'd3
   } state_t;

   localparam logic [7:0] SEG_0     = 8'h3F;
   localparam logic [7:0] SEG_1     = 8'h06;
   localparam logic [7:0] SEG_2     = 8'h5B;
   localparam logic [7:0] SEG_3     = 8'h4F;
   localparam logic [7:0] SEG_4     = 8'h66;
   localparam logic [7:0] SEG_5     = 8'h6D;
   localparam logic [7:0] SEG_6     = 8'h7D;
   localparam logic [7:0] SEG_7     = 8'h07;
   localparam logic [7:0] SEG_8     = 8'h7F;
   localparam logic [7:0] SEG_9     = 8'h6F;
   localparam logic [7:0] SEG_BLANK = 8'h00;
   localparam logic [7:0] SEG_E     = 8'h79;
   localparam logic [7:0] SEG_DP    = 8'h80;

   // Active-high segment pattern for one BCD digit; non-BCD codes blank.
   function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector for a switch level.
// pulse_c is decoded purely from flops, so it carries no path from the input pin.
module edge_sync (
   input  logic clk_2,
   input  logic reset,
   input  logic level,
   output logic pulse_c
);

   logic s1_q;
   logic s2_q;
   logic prev_q;

   // Synchronizer chain plus one-cycle history for edge detection.
   always_ff @(posedge clk_2) begin
      if (reset) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         s1_q   <= level;
         s2_q   <= s1_q;
         prev_q <= s2_q;
      end
   end

   assign pulse_c = s2_q & ~prev_q;

endmodule

// File: rtl/decimal_entry.sv
// Keypad-style decimal entry: accumulates BCD digits into a binary value,
// echoes the last digit on a seven-segment display and hands the number on at commit.
module decimal_entry
   import decimal_entry_pkg::*;
#(
   parameter int unsigned NBITS      = 8,
   parameter int unsigned MAX_DIGITS = 3
) (
   input  logic             clk_2,
   input  logic             reset,
   input  logic [3:0]       digit,
   input  logic             enter,
   input  logic             commit,
   output logic [NBITS-1:0] value,
   output logic             value_valid,
   output logic [1:0]       ndigits,
   output logic             error,
   output logic [7:0]       seg
);

   localparam int unsigned SUM_W = NBITS + 4;

   state_t             state_q;
   state_t             state_nxt;
   logic [NBITS-1:0]   acc_q;
   logic [NBITS-1:0]   acc_nxt;
   logic [NBITS-1:0]   value_nxt;
   logic [1:0]         ndig_nxt;
   logic [3:0]         last_q;
   logic [3:0]         last_nxt;
   logic               valid_nxt;
   logic [7:0]         seg_nxt;
   logic               error_nxt;
   logic [SUM_W-1:0]   sum_c;
   logic               overflow_c;
   logic               enter_ev_c;
   logic               commit_ev_c;

   edge_sync u_enter_sync (
      .clk_2   (clk_2),
      .reset   (reset),
      .level   (enter),
      .pulse_c (enter_ev_c)
   );

   edge_sync u_commit_sync (
      .clk_2   (clk_2),
      .reset   (reset),
      .level   (commit),
      .pulse_c (commit_ev_c)
   );

   // Wide enough that acc*10+9 never wraps before the overflow test.
   assign sum_c      = SUM_W'(acc_q) * SUM_W'(10) + SUM_W'(digit);
   assign overflow_c = |sum_c[SUM_W-1:NBITS];

   // State register.
   always_ff @(posedge clk_2) begin
      if (reset) state_q <= EMPTY;
      else       state_q <= state_nxt;
   end

   // Next state and datapath updates; commit takes priority over enter.
   always_comb begin
      state_nxt = state_q;
      acc_nxt   = acc_q;
      ndig_nxt  = ndigits;
      last_nxt  = last_q;
      value_nxt = value;
      valid_nxt = 1'b0;
      if (commit_ev_c) begin
         case (state_q)
            ENTRY, FULL: begin
               value_nxt = acc_q;
               valid_nxt = 1'b1;
               acc_nxt   = '0;
               ndig_nxt  = 2'd0;
               state_nxt = EMPTY;
            end
            ERROR: begin
               acc_nxt   = '0;
               ndig_nxt  = 2'd0;
               state_nxt = EMPTY;
            end
            default: ;
         endcase
      end else if (enter_ev_c && (state_q == EMPTY || state_q == ENTRY)) begin
         if (digit > 4'd9 || overflow_c) begin
            state_nxt = ERROR;
         end else begin
            acc_nxt   = sum_c[NBITS-1:0];
            ndig_nxt  = ndigits + 2'd1;
            last_nxt  = digit;
            state_nxt = (ndigits + 2'd1 == 2'(MAX_DIGITS)) ? FULL : ENTRY;
         end
      end
   end

   // Display and error flag decoded from the state being entered.
   always_comb begin
      seg_nxt   = SEG_BLANK;
      error_nxt = 1'b0;
      case (state_nxt)
         EMPTY: seg_nxt = SEG_BLANK;
         ENTRY: seg_nxt = bcd_to_seg(last_nxt);
         FULL:  seg_nxt = bcd_to_seg(last_nxt) | SEG_DP;
         ERROR: begin
            seg_nxt   = SEG_E;
            error_nxt = 1'b1;
         end
         default: seg_nxt = SEG_BLANK;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk_2) begin
      if (reset) begin
         acc_q       <= '0;
         last_q      <= 4'd0;
         value       <= '0;
         value_valid <= 1'b0;
         ndigits     <= 2'd0;
         error       <= 1'b0;
         seg         <= SEG_BLANK;
      end else begin
         acc_q       <= acc_nxt;
         last_q      <= last_nxt;
         value       <= value_nxt;
         value_valid <= valid_nxt;
         ndigits     <= ndig_nxt;
         error       <= error_nxt;
         seg         <= seg_nxt;
      end
   end

endmodule

// File: tb/tb_decimal_entry.sv
// Table-driven bench for decimal_entry with a queue scoreboard.
module tb_decimal_entry;

   typedef enum int {OP_ENTER, OP_COMMIT, OP_BOTH} op_t;

   typedef struct {
      op_t        op;
      logic [3:0] dig;
      int         hold;
      logic [7:0] value;
      logic       valid;
      logic [1:0] nd;
      logic       err;
      logic [7:0] seg;
   } vec_t;

   logic       clk_2 = 1'b0;
   logic       reset;
   logic [3:0] digit;
   logic       enter;
   logic       commit;
   logic [7:0] value;
   logic       value_valid;
   logic [1:0] ndigits;
   logic       error;
   logic [7:0] seg;

   int n_vec  = 0;
   int n_miss = 0;

   vec_t vecs[$];
   vec_t exp_q[$];
   logic [1:0] prev_nd;
   logic [7:0] prev_seg;

   decimal_entry #(.NBITS(8), .MAX_DIGITS(3)) dut (
      .clk_2       (clk_2),
      .reset       (reset),
      .digit       (digit),
      .enter       (enter),
      .commit      (commit),
      .value       (value),
      .value_valid (value_valid),
      .ndigits     (ndigits),
      .error       (error),
      .seg         (seg)
   );

   always #5 clk_2 = ~clk_2;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_reset_state(input string nm);
      check({nm, "_value"}, 32'(value), 32'h0);
      check({nm, "_valid"}, 32'(value_valid), 32'h0);
      check({nm, "_nd"}, 32'(ndigits), 32'h0);
      check({nm, "_err"}, 32'(error), 32'h0);
      check({nm, "_seg"}, 32'(seg), 32'h0);
   endtask

   // Raise the level(s), check nothing moves before the 3rd edge, then pop and compare.
   task automatic apply(input int idx, input vec_t v);
      vec_t e;
      @(negedge clk_2);
      digit  = v.dig;
      enter  = (v.op != OP_COMMIT);
      commit = (v.op != OP_ENTER);
      exp_q.push_back(v);
      repeat (2) @(posedge clk_2);
      #1;
      check($sformatf("v%0d_early_nd", idx), 32'(ndigits), 32'(prev_nd));
      check($sformatf("v%0d_early_seg", idx), 32'(seg), 32'(prev_seg));
      @(posedge clk_2);
      #1;
      if (exp_q.size() == 0) begin
         check($sformatf("v%0d_scoreboard_empty", idx), 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check($sformatf("v%0d_value", idx), 32'(value), 32'(e.value));
         check($sformatf("v%0d_valid", idx), 32'(value_valid), 32'(e.valid));
         check($sformatf("v%0d_nd", idx), 32'(ndigits), 32'(e.nd));
         check($sformatf("v%0d_err", idx), 32'(error), 32'(e.err));
         check($sformatf("v%0d_seg", idx), 32'(seg), 32'(e.seg));
         @(posedge clk_2);
         #1;
         check($sformatf("v%0d_valid_drop", idx), 32'(value_valid), 32'h0);
         if (v.hold > 4) begin
            repeat (v.hold - 4) @(posedge clk_2);
            #1;
            check($sformatf("v%0d_hold_nd", idx), 32'(ndigits), 32'(e.nd));
            check($sformatf("v%0d_hold_seg", idx), 32'(seg), 32'(e.seg));
         end
         prev_nd  = e.nd;
         prev_seg = e.seg;
      end
      @(negedge clk_2);
      enter  = 1'b0;
      commit = 1'b0;
      repeat (3) @(posedge clk_2);
   endtask

   initial begin
      //          op         dig  hold value  vld nd  err seg
      vecs.push_back('{OP_ENTER,  4'd1, 0, 8'h00, 1'b0, 2'd1, 1'b0, 8'h06});
      vecs.push_back('{OP_ENTER,  4'd2, 0, 8'h00, 1'b0, 2'd2, 1'b0, 8'h5B});
      vecs.push_back('{OP_ENTER,  4'd3, 0, 8'h00, 1'b0, 2'd3, 1'b0, 8'hCF});
      vecs.push_back('{OP_COMMIT, 4'd0, 0, 8'h7B, 1'b1, 2'd0, 1'b0, 8'h00});
      vecs.push_back('{OP_ENTER,  4'd2, 0, 8'h7B, 1'b0, 2'd1, 1'b0, 8'h5B});
      vecs.push_back('{OP_ENTER,  4'd5, 0, 8'h7B, 1'b0, 2'd2, 1'b0, 8'h6D});
      vecs.push_back('{OP_ENTER,  4'd6, 0, 8'h7B, 1'b0, 2'd2, 1'b1, 8'h79});
      vecs.push_back('{OP_COMMIT, 4'd0, 0, 8'h7B, 1'b0, 2'd0, 1'b0, 8'h00});
      vecs.push_back('{OP_ENTER,  4'hA, 0, 8'h7B, 1'b0, 2'd0, 1'b1, 8'h79});
      vecs.push_back('{OP_ENTER,  4'd4, 0, 8'h7B, 1'b0, 2'd0, 1'b1, 8'h79});
      vecs.push_back('{OP_COMMIT, 4'd0, 0, 8'h7B, 1'b0, 2'd0, 1'b0, 8'h00});
      vecs.push_back('{OP_ENTER,  4'd1, 0, 8'h7B, 1'b0, 2'd1, 1'b0, 8'h06});
      vecs.push_back('{OP_ENTER,  4'd0, 0, 8'h7B, 1'b0, 2'd2, 1'b0, 8'h3F});
      vecs.push_back('{OP_ENTER,  4'd0, 0, 8'h7B, 1'b0, 2'd3, 1'b0, 8'hBF});
      vecs.push_back('{OP_ENTER,  4'd7, 0, 8'h7B, 1'b0, 2'd3, 1'b0, 8'hBF});
      vecs.push_back('{OP_COMMIT, 4'd0, 0, 8'h64, 1'b1, 2'd0, 1'b0, 8'h00});
      vecs.push_back('{OP_ENTER,  4'd5, 10, 8'h64, 1'b0, 2'd1, 1'b0, 8'h6D});
      vecs.push_back('{OP_BOTH,   4'd7, 0, 8'h05, 1'b1, 2'd0, 1'b0, 8'h00});
      vecs.push_back('{OP_ENTER,  4'd4, 0, 8'h05, 1'b0, 2'd1, 1'b0, 8'h66});
      vecs.push_back('{OP_ENTER,  4'd2, 0, 8'h05, 1'b0, 2'd2, 1'b0, 8'h5B});

      reset  = 1'b1;
      digit  = 4'd0;
      enter  = 1'b0;
      commit = 1'b0;
      repeat (2) @(posedge clk_2);
      #1;
      check_reset_state("reset");
      @(negedge clk_2);
      reset = 1'b0;
      repeat (2) @(posedge clk_2);
      prev_nd  = 2'd0;
      prev_seg = 8'h00;

      foreach (vecs[i]) apply(i, vecs[i]);

      // Reset mid-entry while an enter level has reached only the first sync flop.
      @(negedge clk_2);
      digit = 4'd3;
      enter = 1'b1;
      @(posedge clk_2);
      @(negedge clk_2);
      reset = 1'b1;
      @(posedge clk_2);
      #1;
      check_reset_state("midreset");
      @(negedge clk_2);
      reset = 1'b0;
      enter = 1'b0;
      repeat (6) @(posedge clk_2);
      #1;
      check_reset_state("post_reset_quiet");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
